// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_pkg
//  Description : Shared definitions for the count_arbiter slice. Holds the
//                arbiter FSM state encoding, the default counter width, the
//                requester count and index width, and a one-hot helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cnt_pkg;

    // Default counter / run-length width. A run is 1..2**CNT_W ticks.
    localparam int unsigned CNT_W_DEF = 4;

    // Number of requesters sharing the counter and the index width.
    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned REQ_IDX_W = 1;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester index to one-hot requester vector.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [REQ_IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_arbiter_tick_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : tick_cnt
//  Description : CNT_W-bit up-counter with synchronous clear and enable.
//                Clear has priority over enable. Wraps naturally, although
//                the arbiter never enables it past its terminal count.
//  Ports       : clk    in  1      clock
//                rst_n  in  1      synchronous active-low reset
//                clr    in  1      clear counter to zero (priority)
//                en     in  1      increment counter by one
//                out    out CNT_W  registered counter value
//  Revision    : 1.0  initial release
// ============================================================================
module tick_cnt
    import cnt_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] out
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign out = r_cnt;

endmodule
`default_nettype wire

// File: rtl/count_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : count_arbiter
//  Description : Shares one CNT_W-bit clear/enable up-counter between two
//                requesters. Arbitrates round-robin in IDLE, captures the
//                winner's run length as a terminal count, runs the counter
//                (pausable with hold) and pulses done to the owner.
//  Ports       : clk    in  1          clock
//                rst_n  in  1          synchronous active-low reset
//                req    in  2          per-requester run request
//                len0   in  CNT_W      run length of requester 0 (0 = 2**CNT_W)
//                len1   in  CNT_W      run length of requester 1 (0 = 2**CNT_W)
//                hold   in  1          pause counting while in RUN
//                gnt    out 2          one-hot grant pulse
//                done   out 2          one-hot completion pulse
//                busy   out 1          a run is owned (RUN or DONE)
//                owner  out 1          current / last granted requester
//                count  out CNT_W      live counter value
//  Revision    : 1.0  initial release
// ============================================================================
module count_arbiter
    import cnt_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [CNT_W-1:0]     len0,
    input  logic [CNT_W-1:0]     len1,
    input  logic                 hold,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic [REQ_IDX_W-1:0] owner,
    output logic [CNT_W-1:0]     count
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    state_t               r_state;
    logic [REQ_IDX_W-1:0] r_last;
    logic [CNT_W-1:0]     r_tc;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_busy;
    logic [REQ_IDX_W-1:0] r_owner;

    logic                 w_any_req;
    logic [REQ_IDX_W-1:0] w_pick;
    logic [CNT_W-1:0]     w_len_sel;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_at_tc;
    logic                 w_clr;
    logic                 w_en;

    // ------------------------------------------------------------------
    // Arbitration: a lone request wins outright; on a tie the requester
    // that did not win last time is chosen.
    // ------------------------------------------------------------------
    assign w_any_req = |req;
    assign w_pick    = (&req) ? ~r_last : req[1];
    assign w_len_sel = w_pick[0] ? len1 : len0;

    assign w_at_tc   = (w_cnt == r_tc);

    // The counter is cleared on the granting edge and advances only in RUN
    // while not paused and not yet at the terminal count, so it parks at
    // tc (and keeps that value through DONE and IDLE).
    assign w_clr = (r_state == IDLE) && w_any_req;
    assign w_en  = (r_state == RUN) && !hold && !w_at_tc;

    tick_cnt #(
        .CNT_W (CNT_W)
    ) u_tick_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .en    (w_en),
        .out   (w_cnt)
    );

    // ------------------------------------------------------------------
    // Control FSM. gnt and done default low every cycle so each is a
    // single-cycle pulse; they are raised in different states and so can
    // never coincide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= '1;
            r_tc    <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_owner <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt   <= idx_to_onehot(w_pick);
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        // len=0 wraps to all-ones: a full 2**CNT_W-tick run.
                        r_tc    <= w_len_sel - c_one;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!hold && w_at_tc) begin
                        r_done  <= idx_to_onehot(r_owner);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Requests are deliberately not sampled here, which
                    // guarantees one idle cycle between runs.
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign busy  = r_busy;
    assign owner = r_owner;
    assign count = w_cnt;

endmodule
`default_nettype wire
